clk_divider_prog: RTL and testbench
===================================

# clk_divider_prog

Runtime-programmable, multi-channel clock divider producing 50 %-duty-cycle divided clocks from one source clock, for any integer divisor from 2 to 2^DIV_W-1. It supersedes the fixed-parameter divider: each channel has its own divisor, loaded at runtime and applied glitch-free at a period boundary. Each channel also has a glitch-free enable and a rising-edge strobe, so logic in the `clk` domain can track the divided clocks. It sits in the clocking subsystem between the reference clock and peripheral/sampling logic.

## Interface
- NUM_CH, 4, number of independent divider channels
- DIV_W, 8, divisor width in bits
- DIV_RST, 2, divisor of every channel after reset (must be ≥2 and <2^DIV_W)
- clk  in  1  source clock; all logic posedge except one negedge flop per channel
- rst_n  in  1  synchronous, active-low reset
- en  in  NUM_CH  per-channel run request
- div_in  in  NUM_CH*DIV_W  divisor for channel c in bits [c*DIV_W +: DIV_W]
- div_load  in  NUM_CH  one-cycle load request per channel
- div_busy  out  NUM_CH  load pending, not yet applied
- active  out  NUM_CH  channel currently toggling
- clk_out  out  NUM_CH  divided clocks
- rise_stb  out  NUM_CH  one `clk`-cycle pulse per divided-clock period
- err_clr  in  1  clears div_err
- div_err  out  NUM_CH  sticky: rejected load

## Operation
- Per-channel state:
  - div_cur: reset value DIV_RST
  - cnt: 0..div_cur-1
  - pos_q: posedge flop
  - neg_q: negedge flop, samples pos_q
  - pend, div_nxt, active, err
- Counting, while active:
  - cnt increments each posedge and wraps at div_cur-1.
  - pos_q = 1 for cnt in [0, ceil(div_cur/2)-1].
- Output: even div_cur → clk_out = pos_q; odd div_cur → clk_out = pos_q & neg_q.
  - High time is exactly div_cur/2 clk periods for both even and odd divisors.
  - The AND is glitch-free because its inputs change on opposite edges.
- Load handshake:
  - A div_load with pend=0 and div_in ≥ 2 captures div_nxt and sets pend (div_busy).
  - div_load while pend=1, or with div_in < 2, is ignored and sets div_err[c].
- Apply:
  - Active channel: at the posedge where cnt = div_cur-1, div_cur ← div_nxt, pend ← 0, and the new period starts with the new divisor.
  - Inactive channel: the load applies on the next posedge.
- Enable:
  - en rising while inactive: at the next posedge active ← 1, cnt ← 0, pos_q ← 1.
  - en falling: the channel completes the current period. At the wrap posedge active ← 0, cnt holds 0, and clk_out stays 0.
  - No runt pulses are produced.
- rise_stb[c] is 1 in every clk cycle where active=1 and cnt=0.
- div_err is sticky. err_clr clears all bits. If err_clr and a new error coincide in the same cycle, the error wins.

## Timing
- Reset values:
  - Posedge state: cnt=0, pos_q=0, active=0, pend=0, div_busy=0, div_err=0, rise_stb=0, div_cur=DIV_RST.
  - neg_q clears on the first negedge that samples rst_n=0.
  - clk_out=0 from the first posedge with rst_n low. Reset mid-period truncates the output to low and is the only permitted runt.
- Enable latency: en sampled high at posedge t gives active=1 and rise_stb=1 in cycle t..t+1.
  - clk_out rises right after edge t for even divisors, and at the following negedge for odd divisors.
- Load latency: div_busy rises one posedge after div_load and falls at the wrap posedge that applies the divisor.
- Simultaneous events:
  - en falling during a pending load: the load still applies at the final wrap.
  - div_load in the apply cycle while pend=1: rejected, error set.
- Divisor changes between odd and even values take effect on whole periods only.

## Structure
- Package clk_div_pkg holds:
  - DIV_MIN = 2
  - default DIV_W
  - a function half_hi(N) = ceil(N/2)
- Sub-module clk_div_chan implements one channel (counter, pos/neg flops, pend logic, enable FSM IDLE→RUN→STOPPING→IDLE).
- The top generates NUM_CH instances of clk_div_chan, plus the shared err_clr fan-out.

## Test plan
- Reset, then en[0]=1 with DIV_RST=2 → clk_out[0] period 2 clk, high 1 clk; rise_stb pulses every 2 cycles.
- Load div 5 on ch1 → busy until wrap; then period 5 clk, high time 2.5 clk measured edge to edge; rise_stb every 5 cycles.
- Change ch2 from 6 to 3 mid-period → current 6-cycle period completes intact, next period is 3 cycles, no runt.
- Load 1 and 0 on ch3, then double-load while busy → each rejected, div_err[3]=1, divisor unchanged; err_clr → 0.
- Drop en[0] at cnt=1 of div 4 → period finishes, active=0 at wrap, clk_out held 0; re-enable restarts at cnt=0.
- Assert rst_n=0 mid-high phase on all channels → clk_out=0 by the next negedge; all outputs match the reset values.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
//   - DIV_W_DEFAULT : default divisor width in bits
//   - DIV_MIN       : smallest divisor a channel accepts
//   - chan_state_e  : per-channel enable FSM states
//   - half_hi()     : number of counter states with the posedge flop high
package clk_div_pkg;

    localparam int DIV_W_DEFAULT = 8;
    localparam int DIV_MIN       = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } chan_state_e;

    // ceil(n/2): the posedge flop is high for this many counts of a period
    function automatic logic [31:0] half_hi(input logic [31:0] n);
        half_hi = (n >> 1) + {31'd0, n[0]};
    endfunction

endpackage

// File: rtl/clk_divider_prog_if.sv
// Control/status bundle of the programmable clock divider.
//   master : drives en, div_in, div_load, err_clr; observes status/clocks
//   slave  : the divider itself
//   en/div_load/div_busy/active/clk_out/rise_stb/div_err are one bit per channel,
//   div_in packs channel c's divisor in bits [c*DIV_W +: DIV_W].
interface clk_divider_prog_if
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = DIV_W_DEFAULT
);

    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*DIV_W-1:0] div_in;
    logic [NUM_CH-1:0]       div_load;
    logic                    err_clr;
    logic [NUM_CH-1:0]       div_busy;
    logic [NUM_CH-1:0]       active;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       rise_stb;
    logic [NUM_CH-1:0]       div_err;

    modport master (
        output en, div_in, div_load, err_clr,
        input  div_busy, active, clk_out, rise_stb, div_err
    );

    modport slave (
        input  en, div_in, div_load, err_clr,
        output div_busy, active, clk_out, rise_stb, div_err
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, posedge/negedge shaping flops,
// load handshake with sticky error, and the IDLE/RUN/STOPPING enable FSM.
//   clk, rst_n        : source clock, synchronous active-low reset
//   en                : run request
//   div_in, div_load  : divisor and one-cycle load strobe
//   err_clr           : clears the sticky error
//   div_busy, active  : load pending / channel toggling
//   clk_out, rise_stb : divided clock and its clk-domain rising strobe
//   div_err           : sticky rejected-load flag
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEFAULT,
    parameter int DIV_RST = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    input  logic             err_clr,
    output logic             div_busy,
    output logic             active,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             div_err
);

    localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] DIV_MIN_V = DIV_W'(DIV_MIN);

    chan_state_e      state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_cur_q, div_cur_d;
    logic [DIV_W-1:0] div_nxt_q, div_nxt_d;
    logic             pos_q, pos_d;
    logic             neg_q;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             active_q, active_d;
    logic             stb_q, stb_d;
    logic             load_ok_s;
    logic             load_bad_s;
    logic             wrap_s;

    // Next-state logic: counter, shaping flop, divisor apply, load handshake, enable FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pos_d     = pos_q;
        div_cur_d = div_cur_q;
        div_nxt_d = div_nxt_q;
        pend_d    = pend_q;

        load_ok_s  = div_load && !pend_q && (div_in >= DIV_MIN_V);
        load_bad_s = div_load && !load_ok_s;
        wrap_s     = (cnt_q == (div_cur_q - DIV_W'(1)));

        case (state_q)
            ST_IDLE: begin
                // nothing is toggling, so a pending divisor can go in straight away
                if (pend_q) begin
                    div_cur_d = div_nxt_q;
                    pend_d    = 1'b0;
                end else begin
                    div_cur_d = div_cur_q;
                end
                cnt_d = '0;
                if (en) begin
                    state_d = ST_RUN;
                    pos_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    pos_d   = 1'b0;
                end
            end
            ST_RUN, ST_STOPPING: begin
                if (wrap_s) begin
                    // period boundary: only place a divisor change or a stop can happen
                    if (pend_q) begin
                        div_cur_d = div_nxt_q;
                        pend_d    = 1'b0;
                    end else begin
                        div_cur_d = div_cur_q;
                    end
                    cnt_d = '0;
                    if (en) begin
                        state_d = ST_RUN;
                        pos_d   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        pos_d   = 1'b0;
                    end
                end else begin
                    cnt_d   = cnt_q + DIV_W'(1);
                    pos_d   = ((32'(cnt_q) + 32'd1) < half_hi(32'(div_cur_q)));
                    state_d = en ? ST_RUN : ST_STOPPING;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pos_d   = 1'b0;
            end
        endcase

        // load is only checked against the pend value seen this cycle, so a
        // load arriving in the apply cycle is still rejected
        if (load_ok_s) begin
            div_nxt_d = div_in;
            pend_d    = 1'b1;
        end else begin
            div_nxt_d = div_nxt_q;
        end

        // a fresh error outranks a simultaneous clear
        if (load_bad_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        active_d = (state_d != ST_IDLE);
        stb_d    = active_d && (cnt_d == '0);
    end

    // Posedge state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_cur_q <= DIV_RST_V;
            div_nxt_q <= DIV_RST_V;
            pos_q     <= 1'b0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            active_q  <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_cur_q <= div_cur_d;
            div_nxt_q <= div_nxt_d;
            pos_q     <= pos_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            active_q  <= active_d;
            stb_q     <= stb_d;
        end
    end

    // Half-cycle-delayed copy of pos_q, used to stretch odd-divisor high time by half a clock
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    // AND of flops switching on opposite edges cannot glitch
    assign clk_out  = div_cur_q[0] ? (pos_q & neg_q) : pos_q;
    assign div_busy = pend_q;
    assign active   = active_q;
    assign rise_stb = stb_q;
    assign div_err  = err_q;

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable multi-channel 50%-duty clock divider.
//   clk   : source clock
//   rst_n : synchronous active-low reset
//   bus   : per-channel enable/divisor load/status and divided clocks
//           (see clk_divider_prog_if), err_clr fans out to every channel
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = DIV_W_DEFAULT,
    parameter int DIV_RST = 2
) (
    input logic                clk,
    input logic                rst_n,
    clk_divider_prog_if.slave  bus
);

    logic [NUM_CH-1:0] busy_s;
    logic [NUM_CH-1:0] active_s;
    logic [NUM_CH-1:0] clk_out_s;
    logic [NUM_CH-1:0] stb_s;
    logic [NUM_CH-1:0] err_s;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (bus.en[c]),
            .div_in   (bus.div_in[c*DIV_W +: DIV_W]),
            .div_load (bus.div_load[c]),
            .err_clr  (bus.err_clr),
            .div_busy (busy_s[c]),
            .active   (active_s[c]),
            .clk_out  (clk_out_s[c]),
            .rise_stb (stb_s[c]),
            .div_err  (err_s[c])
        );
    end

    assign bus.div_busy = busy_s;
    assign bus.active   = active_s;
    assign bus.clk_out  = clk_out_s;
    assign bus.rise_stb = stb_s;
    assign bus.div_err  = err_s;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: a half-cycle monitor measures every
// complete divided-clock period (rise to rise, in half clk periods) and compares
// it against expectations queued when the stimulus is driven.
module tb_clk_divider_prog;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    clk_divider_prog_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    clk_divider_prog #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DIV_RST(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int ch;
        int per2;
        int hi2;
    } exp_t;

    typedef struct {
        int ch;
        int div;
        int nper;
        int per2;
        int hi2;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input int d);
        logic [31:0] dv;
        dv = d;
        bus.div_in[ch*DIV_W +: DIV_W] = dv[DIV_W-1:0];
        bus.div_load[ch] = 1'b1;
        step();
        bus.div_load = '0;
    endtask

    task automatic wait_idle(input int ch);
        for (int i = 0; i < 600 && bus.active[ch] !== 1'b0; i++) step();
        chk("stop_active", 32'(bus.active[ch]), 32'd0);
        chk("stop_clk_low", 32'(bus.clk_out[ch]), 32'd0);
        step();
        step();
        chk("sb_drained", exp_q.size(), 32'd0);
    endtask

    // Enable ch, expect nper identical periods, count strobes, then stop cleanly
    task automatic run_periods(input int ch, input int div, input int nper,
                               input int per2, input int hi2);
        int   stb;
        exp_t e;
        for (int p = 0; p < nper; p++) begin
            e.ch = ch; e.per2 = per2; e.hi2 = hi2;
            exp_q.push_back(e);
        end
        bus.en[ch] = 1'b1;
        step();
        chk("en_active", 32'(bus.active[ch]), 32'd1);
        chk("en_stb", 32'(bus.rise_stb[ch]), 32'd1);
        stb = 0;
        repeat (nper * div) begin
            step();
            if (bus.rise_stb[ch] === 1'b1) stb++;
        end
        chk("stb_count", stb, nper);
        bus.en[ch] = 1'b0;
        wait_idle(ch);
    endtask

    // Half-cycle monitor: measures rise-to-rise period and high time per channel
    logic [NUM_CH-1:0] prev_s = '0;
    bit                started[NUM_CH];
    int                per_cnt[NUM_CH];
    int                hi_cnt[NUM_CH];

    always begin : mon
        exp_t e;
        @(clk);
        #2;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.active[c] !== 1'b1) started[c] = 1'b0;
            if (bus.clk_out[c] === 1'b1 && prev_s[c] !== 1'b1) begin
                chk("stb_at_rise", 32'(bus.rise_stb[c]), 32'd1);
                if (started[c]) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL sb_unexpected: ch%0d got period %0d half-cycles, expected none",
                                 c, per_cnt[c]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_channel", c, e.ch);
                        chk("period_half", per_cnt[c], e.per2);
                        chk("high_half", hi_cnt[c], e.hi2);
                    end
                end
                started[c] = 1'b1;
                per_cnt[c] = 0;
                hi_cnt[c]  = 0;
            end
            per_cnt[c]++;
            if (bus.clk_out[c] === 1'b1) hi_cnt[c]++;
            prev_s[c] = bus.clk_out[c];
        end
    end

    initial begin
        exp_t e;
        vecs[0] = '{ch: 1, div: 5,   nper: 3, per2: 10,  hi2: 5};
        vecs[1] = '{ch: 2, div: 3,   nper: 3, per2: 6,   hi2: 3};
        vecs[2] = '{ch: 3, div: 4,   nper: 2, per2: 8,   hi2: 4};
        vecs[3] = '{ch: 0, div: 7,   nper: 2, per2: 14,  hi2: 7};
        vecs[4] = '{ch: 1, div: 255, nper: 1, per2: 510, hi2: 255};
        vecs[5] = '{ch: 2, div: 6,   nper: 2, per2: 12,  hi2: 6};
        vecs[6] = '{ch: 3, div: 2,   nper: 2, per2: 4,   hi2: 2};

        bus.en       = '0;
        bus.div_in   = '0;
        bus.div_load = '0;
        bus.err_clr  = 1'b0;

        // reset values
        repeat (3) step();
        chk("rst_clk_out", 32'(bus.clk_out), 32'd0);
        chk("rst_active", 32'(bus.active), 32'd0);
        chk("rst_busy", 32'(bus.div_busy), 32'd0);
        chk("rst_err", 32'(bus.div_err), 32'd0);
        chk("rst_stb", 32'(bus.rise_stb), 32'd0);
        rst_n = 1'b1;
        step();

        // reset divisor of 2 on ch0
        run_periods(0, 2, 3, 4, 2);

        // table: load on an idle channel applies the next cycle, then run
        for (int v = 0; v < 7; v++) begin
            load(vecs[v].ch, vecs[v].div);
            chk("ld_busy", 32'(bus.div_busy[vecs[v].ch]), 32'd1);
            step();
            chk("ld_applied", 32'(bus.div_busy[vecs[v].ch]), 32'd0);
            run_periods(vecs[v].ch, vecs[v].div, vecs[v].nper, vecs[v].per2, vecs[v].hi2);
        end

        // ch2: 6 -> 3 mid-period; the 6 period completes, rise moves half a cycle later
        load(2, 6);
        step();
        e = '{ch: 2, per2: 13, hi2: 6}; exp_q.push_back(e);
        e = '{ch: 2, per2: 6,  hi2: 3}; exp_q.push_back(e);
        exp_q.push_back(e);
        bus.en[2] = 1'b1;
        step();
        step();
        step();
        load(2, 3);
        chk("mid_busy", 32'(bus.div_busy[2]), 32'd1);
        step();
        step();
        chk("mid_busy_hold", 32'(bus.div_busy[2]), 32'd1);
        step();
        chk("mid_busy_clear", 32'(bus.div_busy[2]), 32'd0);
        repeat (6) step();
        bus.en[2] = 1'b0;
        wait_idle(2);

        // ch0 div 4: drop en at cnt=1, period finishes, then restart
        load(0, 4);
        step();
        bus.en[0] = 1'b1;
        step();
        chk("drop_start_hi", 32'(bus.clk_out[0]), 32'd1);
        step();
        bus.en[0] = 1'b0;
        chk("drop_cnt1_hi", 32'(bus.clk_out[0]), 32'd1);
        step();
        chk("drop_cnt2_lo", 32'(bus.clk_out[0]), 32'd0);
        chk("drop_still_active", 32'(bus.active[0]), 32'd1);
        step();
        step();
        chk("drop_inactive", 32'(bus.active[0]), 32'd0);
        chk("drop_stb", 32'(bus.rise_stb[0]), 32'd0);
        repeat (3) step();
        chk("drop_held_low", 32'(bus.clk_out[0]), 32'd0);
        e = '{ch: 0, per2: 8, hi2: 4}; exp_q.push_back(e);
        bus.en[0] = 1'b1;
        step();
        chk("re_en_active", 32'(bus.active[0]), 32'd1);
        chk("re_en_stb", 32'(bus.rise_stb[0]), 32'd1);
        chk("re_en_clk", 32'(bus.clk_out[0]), 32'd1);
        repeat (4) step();
        bus.en[0] = 1'b0;
        wait_idle(0);

        // ch3 rejected loads and sticky error
        load(3, 1);
        chk("err_div1", 32'(bus.div_err), 32'h8);
        chk("err_div1_busy", 32'(bus.div_busy[3]), 32'd0);
        bus.err_clr = 1'b1; step(); bus.err_clr = 1'b0;
        chk("err_clr1", 32'(bus.div_err), 32'd0);
        load(3, 0);
        chk("err_div0", 32'(bus.div_err), 32'h8);
        bus.err_clr = 1'b1; step(); bus.err_clr = 1'b0;
        chk("err_clr2", 32'(bus.div_err), 32'd0);
        bus.err_clr = 1'b1;
        load(3, 1);
        bus.err_clr = 1'b0;
        chk("err_wins_clr", 32'(bus.div_err[3]), 32'd1);
        bus.err_clr = 1'b1; step(); bus.err_clr = 1'b0;
        load(3, 5);
        chk("dbl_busy", 32'(bus.div_busy[3]), 32'd1);
        load(3, 7);
        chk("dbl_err", 32'(bus.div_err[3]), 32'd1);
        chk("dbl_busy_clear", 32'(bus.div_busy[3]), 32'd0);
        bus.err_clr = 1'b1; step(); bus.err_clr = 1'b0;
        run_periods(3, 5, 2, 10, 5);

        // reset in the high phase of every channel, with an error and a pending load
        load(0, 4); step();
        load(1, 5); step();
        load(2, 6); step();
        load(3, 7); step();
        load(0, 0);
        bus.div_in[3*DIV_W +: DIV_W] = 8'd2;
        bus.div_load[3] = 1'b1;
        bus.en = 4'hF;
        step();
        bus.div_load = '0;
        chk("pre_rst_busy", 32'(bus.div_busy[3]), 32'd1);
        chk("pre_rst_err", 32'(bus.div_err), 32'd1);
        step();
        chk("pre_rst_all_hi", 32'(bus.clk_out), 32'hF);
        rst_n  = 1'b0;
        bus.en = '0;
        step();
        chk("rst_pos_clk", 32'(bus.clk_out), 32'd0);
        @(negedge clk);
        #2;
        chk("rst_neg_clk", 32'(bus.clk_out), 32'd0);
        chk("rst2_active", 32'(bus.active), 32'd0);
        chk("rst2_busy", 32'(bus.div_busy), 32'd0);
        chk("rst2_stb", 32'(bus.rise_stb), 32'd0);
        chk("rst2_err", 32'(bus.div_err), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // ch1 back at the reset divisor
        run_periods(1, 2, 2, 4, 2);

        chk("final_sb_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
